// File: rtl/duty_ramp_ctrl.sv
// Slew-limited duty-cycle tracker placed between the SPI duty register and the PWM peripheral.
// Optional fast-stop (target 0x00 forces an immediate stop) is enabled by defining DUTY_RAMP_FAST_STOP_EN.
module duty_ramp_ctrl #(
   parameter int PRESCALE = 100,
   parameter int STEP     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] target_duty,
   input  logic       ramp_en,
   output logic [7:0] duty_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;

   localparam logic [9:0] PCNT_LAST = 10'(PRESCALE - 1);
   localparam logic [8:0] STEP9     = 9'(STEP);

   logic [1:0] state;
   logic [9:0] pcnt;

   logic [1:0] state_nxt;
   logic [9:0] pcnt_nxt;
   logic [7:0] duty_nxt;
   logic       done_nxt;
   logic       busy_nxt;

   logic [8:0] tgt9;
   logic [8:0] duty9;
   logic [8:0] gap;
   logic [8:0] stepped9;
   logic       above;
   logic       below;
   logic       reached;
   logic       fast_stop;

`ifdef DUTY_RAMP_FAST_STOP_EN
   assign fast_stop = (target_duty == 8'h00);
`else
   assign fast_stop = 1'b0;
`endif

   // Step arithmetic is 9 bits wide; clamping to the target when the gap is
   // within one step means the result can never overshoot or wrap.
   always_comb begin
      tgt9     = {1'b0, target_duty};
      duty9    = {1'b0, duty_out};
      above    = (target_duty > duty_out);
      below    = (target_duty < duty_out);
      gap      = above ? (tgt9 - duty9) : (duty9 - tgt9);
      stepped9 = tgt9;
      if (gap > STEP9) begin
         stepped9 = above ? (duty9 + STEP9) : (duty9 - STEP9);
      end
      reached  = (stepped9 == tgt9);
   end

   always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      duty_nxt  = duty_out;
      done_nxt  = 1'b0;
      if (!ena) begin
         state_nxt = state;
      end else if (fast_stop) begin
         state_nxt = ST_IDLE;
         pcnt_nxt  = 10'd0;
         duty_nxt  = 8'h00;
         done_nxt  = (duty_out != 8'h00);
      end else if (!ramp_en) begin
         state_nxt = ST_IDLE;
         pcnt_nxt  = 10'd0;
         duty_nxt  = target_duty;
      end else begin
         case (state)
            ST_IDLE: begin
               if (above) begin
                  state_nxt = ST_UP;
                  pcnt_nxt  = 10'd0;
               end else if (below) begin
                  state_nxt = ST_DOWN;
                  pcnt_nxt  = 10'd0;
               end
            end
            ST_UP, ST_DOWN: begin
               // Direction follows the live target every cycle; pcnt is kept
               // across a reversal so the step cadence is not disturbed.
               if (!above && !below) begin
                  state_nxt = ST_IDLE;
                  pcnt_nxt  = 10'd0;
                  done_nxt  = 1'b1;
               end else if (pcnt == PCNT_LAST) begin
                  pcnt_nxt = 10'd0;
                  duty_nxt = stepped9[7:0];
                  if (reached) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = above ? ST_UP : ST_DOWN;
                  end
               end else begin
                  pcnt_nxt  = pcnt + 10'd1;
                  state_nxt = above ? ST_UP : ST_DOWN;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               pcnt_nxt  = 10'd0;
            end
         endcase
      end
      busy_nxt = (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pcnt     <= 10'd0;
         duty_out <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pcnt     <= pcnt_nxt;
         duty_out <= duty_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Bench for duty_ramp_ctrl: instance a (PRESCALE=4, STEP=16) and instance b (PRESCALE=1, STEP=200),
// each tracked every cycle by a cycle-count model plus directed literal expectations.
module tb_duty_ramp_ctrl;

   localparam int PA = 4;
   localparam int SA = 16;
   localparam int PB = 1;
   localparam int SB = 200;

   logic       clk;
   logic       rst;
   logic       ena_a, ramp_en_a, ena_b, ramp_en_b;
   logic [7:0] target_a, target_b;
   logic [7:0] duty_a, duty_b;
   logic       busy_a, busy_b, done_a, done_b;
   logic [1:0] state_a, state_b;

   int n_checks = 0;
   int n_fail   = 0;

   duty_ramp_ctrl #(.PRESCALE(PA), .STEP(SA)) dut_a (
      .clk(clk), .rst(rst), .ena(ena_a), .target_duty(target_a), .ramp_en(ramp_en_a),
      .duty_out(duty_a), .busy(busy_a), .done(done_a), .dbg_state(state_a)
   );

   duty_ramp_ctrl #(.PRESCALE(PB), .STEP(SB)) dut_b (
      .clk(clk), .rst(rst), .ena(ena_b), .target_duty(target_b), .ramp_en(ramp_en_b),
      .duty_out(duty_b), .busy(busy_b), .done(done_b), .dbg_state(state_b)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- comparison helper ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Counts elapsed cycles since the ramp started or last stepped; a step fires
   // once that count reaches the prescale value.
   typedef struct {
      logic [7:0] duty;
      bit         ramping;
      int         ticks;
      bit         done;
   } model_t;

   model_t ma, mb;
   bit     model_live = 1'b0;

   function automatic model_t model_next(model_t m, int p, int s, bit r, bit en, bit re,
                                         logic [7:0] tgt);
      model_t n = m;
      int gap;
      int move;
      if (r) begin
         n.duty = 8'h00; n.ramping = 1'b0; n.ticks = 0; n.done = 1'b0;
         return n;
      end
      n.done = 1'b0;
      if (!en) return n;
`ifdef DUTY_RAMP_FAST_STOP_EN
      if (tgt == 8'h00) begin
         n.done = (m.duty != 8'h00); n.duty = 8'h00; n.ramping = 1'b0; n.ticks = 0;
         return n;
      end
`endif
      if (!re) begin
         n.duty = tgt; n.ramping = 1'b0; n.ticks = 0;
         return n;
      end
      if (!m.ramping) begin
         if (tgt != m.duty) begin
            n.ramping = 1'b1; n.ticks = 0;
         end
         return n;
      end
      if (tgt == m.duty) begin
         n.ramping = 1'b0; n.done = 1'b1; n.ticks = 0;
         return n;
      end
      n.ticks = m.ticks + 1;
      if (n.ticks == p) begin
         n.ticks = 0;
         gap  = int'(tgt) - int'(m.duty);
         move = (gap > 0) ? gap : -gap;
         if (move > s) move = s;
         n.duty = 8'(int'(m.duty) + ((gap > 0) ? move : -move));
         if (n.duty == tgt) begin
            n.ramping = 1'b0; n.done = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma = model_next(ma, PA, SA, rst, ena_a, ramp_en_a, target_a);
      mb = model_next(mb, PB, SB, rst, ena_b, ramp_en_b, target_b);
      if (rst) model_live = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_live) begin
         chk("a_duty", duty_a, ma.duty);
         chk("a_busy", {7'b0, busy_a}, {7'b0, ma.ramping});
         chk("a_done", {7'b0, done_a}, {7'b0, ma.done});
         chk("b_duty", duty_b, mb.duty);
         chk("b_busy", {7'b0, busy_b}, {7'b0, mb.ramping});
         chk("b_done", {7'b0, done_b}, {7'b0, mb.done});
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_duty_a(input string name, input logic [7:0] val, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (duty_a == val) break;
      end
      chk(name, duty_a, val);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int dones;
      logic [7:0] exp_d;
      rst = 1'b1; ena_a = 1'b1; ramp_en_a = 1'b1; target_a = 8'h00;
      ena_b = 1'b1; ramp_en_b = 1'b0; target_b = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_duty", duty_a, 8'h00);
      chk("reset_busy", {7'b0, busy_a}, 8'h00);
      chk("reset_done", {7'b0, done_a}, 8'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Rising ramp 0x00 -> 0x40, one 16-step every 4 cycles
      target_a = 8'h40;
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         exp_d = (k >= 16) ? 8'h40 : 8'((k / 4) * 16);
         chk("up_duty", duty_a, exp_d);
         chk("up_done", {7'b0, done_a}, {7'b0, (k == 16)});
         if (k >= 1) chk("up_busy", {7'b0, busy_a}, {7'b0, (k <= 15)});
      end

      // Small downward gap: single clamped step, no overshoot
      target_a = 8'h35;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         chk("clamp_duty", duty_a, (k >= 4) ? 8'h35 : 8'h40);
         chk("clamp_done", {7'b0, done_a}, {7'b0, (k == 4)});
      end

      // Reversal mid-ramp at 0x30
      ramp_en_a = 1'b0; target_a = 8'h00;
      @(negedge clk);
      chk("bypass_zero", duty_a, 8'h00);
      ramp_en_a = 1'b1; target_a = 8'hF0;
      wait_duty_a("rev_reach30", 8'h30, 40);
      target_a = 8'h10;
      dones = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) chk("rev_state_down", {6'b0, state_a}, 8'd2);
         exp_d = (k < 4) ? 8'h30 : ((k < 8) ? 8'h20 : 8'h10);
         chk("rev_duty", duty_a, exp_d);
         if (done_a) dones++;
      end
      chk("rev_done_count", 8'(dones), 8'd1);

      // Bypass
      ramp_en_a = 1'b0; target_a = 8'hA5;
      @(negedge clk);
      chk("bypass_duty", duty_a, 8'hA5);
      chk("bypass_done", {7'b0, done_a}, 8'h00);
      chk("bypass_busy", {7'b0, busy_a}, 8'h00);

      // Target moved onto duty_out mid-ramp without a step
      ramp_en_a = 1'b1; target_a = 8'hC5;
      repeat (5) @(negedge clk);
      chk("meet_step", duty_a, 8'hB5);
      target_a = 8'hB5;
      @(negedge clk);
      chk("meet_done", {7'b0, done_a}, 8'h01);
      chk("meet_busy", {7'b0, busy_a}, 8'h00);
      @(negedge clk);
      chk("meet_done_clear", {7'b0, done_a}, 8'h00);

      // Enable low holds everything mid-ramp
      target_a = 8'h55;
      repeat (2) @(negedge clk);
      ena_a = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("hold_duty", duty_a, 8'hB5);
         chk("hold_busy", {7'b0, busy_a}, 8'h01);
      end
      ena_a = 1'b1;
      wait_duty_a("hold_resume", 8'h55, 40);

      // Reset mid-ramp at 0x30, then ramp again from 0x00
      ramp_en_a = 1'b0; target_a = 8'h00;
      @(negedge clk);
      ramp_en_a = 1'b1; target_a = 8'h80;
      wait_duty_a("rst_reach30", 8'h30, 40);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_duty", duty_a, 8'h00);
      chk("rst_mid_busy", {7'b0, busy_a}, 8'h00);
      chk("rst_mid_done", {7'b0, done_a}, 8'h00);
      ramp_en_a = 1'b0; target_a = 8'hAA;
      @(negedge clk);
      chk("rst_priority", duty_a, 8'h00);
      ramp_en_a = 1'b1; target_a = 8'h80; rst = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("rst_rerun", duty_a, (k == 4) ? 8'h10 : 8'h00);
      end
      wait_duty_a("rst_rerun_end", 8'h80, 60);

      // Target 0x00 from 0x80
      target_a = 8'h00;
`ifdef DUTY_RAMP_FAST_STOP_EN
      @(negedge clk);
      chk("fast_stop_duty", duty_a, 8'h00);
      chk("fast_stop_done", {7'b0, done_a}, 8'h01);
      @(negedge clk);
      chk("fast_stop_done_clear", {7'b0, done_a}, 8'h00);
`else
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("zero_ramp", duty_a, (k == 4) ? 8'h70 : 8'h80);
      end
      wait_duty_a("zero_ramp_end", 8'h00, 60);
`endif

      // Instance b: big step, no wrap, one step per cycle
      target_b = 8'h80;
      @(negedge clk);
      chk("b_bypass", duty_b, 8'h80);
      ramp_en_b = 1'b1; target_b = 8'hFF;
      @(negedge clk);
      chk("b_start", duty_b, 8'h80);
      @(negedge clk);
      chk("b_nowrap", duty_b, 8'hFF);
      chk("b_nowrap_done", {7'b0, done_b}, 8'h01);
      target_b = 8'h01;
      @(negedge clk);
      chk("b_down0", duty_b, 8'hFF);
      @(negedge clk);
      chk("b_down1", duty_b, 8'h37);
      @(negedge clk);
      chk("b_down2", duty_b, 8'h01);
      chk("b_down_done", {7'b0, done_b}, 8'h01);
      @(negedge clk);
      chk("b_idle", {7'b0, busy_b}, 8'h00);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/duty_ramp_ctrl.md
DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 Parameter PRESCALE, default 100: clock cycles per ramp step; legal range 1..1023.
REQ-002 Parameter STEP, default 1: duty increment per step; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  block enable; when low, all state holds.
REQ-006 target_duty  input  8  requested duty cycle, driven from the SPI pwm_duty_cycle register.
REQ-007 ramp_en  input  1  1 = slew-limited tracking; 0 = bypass.
REQ-008 duty_out  output  8  slew-limited duty cycle, driven into the PWM peripheral's duty input.
REQ-009 busy  output  1  high while state is UP or DOWN.
REQ-010 done  output  1  single-cycle pulse on the edge where duty_out reaches target_duty at the end of a ramp.

Function
REQ-011 States SHALL be IDLE, UP and DOWN, with a 10-bit prescaler counter pcnt.
REQ-012 IDLE, ena=1, ramp_en=1, target_duty>duty_out: -> UP, pcnt<=0; if target_duty<duty_out: -> DOWN, pcnt<=0; if equal: stay IDLE.
REQ-013 In UP/DOWN, pcnt SHALL increment each cycle; on an edge with pcnt==PRESCALE-1, pcnt<=0 and a step occurs.
REQ-014 Step: if |target_duty-duty_out|<=STEP then duty_out<=target_duty, else duty_out<=duty_out+/-STEP toward target; 9-bit arithmetic, no overshoot, no 8-bit wrap-around.
REQ-015 First step SHALL occur PRESCALE cycles after the IDLE->UP/DOWN edge; subsequent steps every PRESCALE cycles.
REQ-016 A step that lands on target_duty SHALL assert done for that one cycle and return the state to IDLE.
REQ-017 Direction SHALL be re-evaluated every cycle; on target reversal, UP<->DOWN switches without clearing pcnt.
REQ-018 If target_duty equals duty_out mid-ramp without a step, the state SHALL return to IDLE next edge with done pulsed.
REQ-019 ramp_en=0, ena=1: duty_out<=target_duty next edge, state<=IDLE, pcnt<=0, done=0.
REQ-020 ena=0: duty_out, state and pcnt SHALL hold; done SHALL be 0.
REQ-021 PRESCALE=1: one step per cycle.
REQ-022 done and busy SHALL be registered outputs.

Reset
REQ-023 rst=1 at an edge: duty_out=0x00, state=IDLE, pcnt=0, busy=0, done=0.
REQ-024 rst SHALL take priority over ena and ramp_en.
REQ-025 rst mid-ramp SHALL abort the ramp without a done pulse.
REQ-026 After rst releases, the block SHALL ramp from 0x00 toward the current target_duty.

Configuration
REQ-027 Macro DUTY_RAMP_FAST_STOP_EN SHALL select fast-stop behaviour.
REQ-028 With DUTY_RAMP_FAST_STOP_EN defined, target_duty==0x00 with ena=1 SHALL force duty_out<=0x00 next edge, state<=IDLE and one done pulse (done only if duty_out was nonzero), regardless of ramp_en.
REQ-029 Without DUTY_RAMP_FAST_STOP_EN, target 0x00 SHALL ramp down like any other value.

Verification
REQ-030 PRESCALE=4, STEP=16, duty_out=0x00, target 0x40: duty_out steps 0x10/0x20/0x30/0x40 at +4/+8/+12/+16 cycles; done at +16 only; busy high +1..+15.
REQ-031 PRESCALE=4, STEP=16, duty_out=0x40, target 0x35: duty_out 0x40->0x35 in one step at +4 (no overshoot); done pulse.
REQ-032 Ramp 0x00->0xF0 with STEP=16; at duty_out=0x30 the target changes to 0x10: state becomes DOWN; duty_out 0x20 then 0x10; done once.
REQ-033 Target 0xFF with STEP=200 from 0x80: duty_out reaches 0xFF without wrapping through 0x00.
REQ-034 ramp_en=0, target 0xA5: duty_out=0xA5 one edge later; done=0.
REQ-035 rst asserted mid-ramp at duty_out=0x30: duty_out=0x00, busy=0, no done; with DUTY_RAMP_FAST_STOP_EN, target 0x00 from 0x80 gives duty_out=0x00 next edge plus a done pulse.
